// File: rtl/dmem_resp_pkg.sv
// Shared types and defaults for the dmem_resp data-memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_BUSY = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  localparam int          DM_DATA_W    = 32;
  localparam int          DM_ADDR_W    = 16;
  localparam int          DM_CNT_W     = 4;
  localparam logic [31:0] DM_HALT_ADDR = 32'h0000_0080;

endpackage

// File: rtl/dmem_resp_if.sv
// CPU <-> data-memory port: request (re/we/a/wd) and response (rd/stall).
interface dmem_resp_if #(
  parameter int DATA_W = 32
) ();
  logic              re;
  logic              we;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd;
  logic              stall;

  modport master (output re, we, a, wd, input rd, stall);
  modport slave  (input re, we, a, wd, output rd, stall);
endinterface

// File: rtl/dmem_resp_array.sv
// Single-port word RAM with synchronous write and synchronous read.
module dmem_resp_array
  import dmem_resp_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W,
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rd_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wd_i;
    rd_o <= mem[addr_i];
  end
endmodule

// File: rtl/dmem_resp.sv
// Fixed-latency data-memory responder with stall, access/stall counters and
// optional halt-store decode (enabled by defining DMEM_HALT_EN).
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int              DATA_W    = DM_DATA_W,
  parameter int              ADDR_W    = DM_ADDR_W,
  parameter int              LATENCY   = 2,
  parameter logic [DATA_W-1:0] HALT_ADDR = DATA_W'(DM_HALT_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  dmem_resp_if.slave        bus,
  output logic              done,
  output logic [DATA_W-1:0] done_data,
  output logic [31:0]       acc_cnt,
  output logic [31:0]       stall_cnt
);
`ifdef DMEM_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  dm_state_e           state_q, state_d;
  logic [DM_CNT_W-1:0] cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   a_q, wd_q;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   done_data_q, done_data_d;
  logic [31:0]         acc_q, acc_d, stl_q, stl_d;
  logic                latch, mem_we, stall, halt_hit;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_rd;
  logic                unused_a;

  assign halt_hit = HALT_EN && (a_q == HALT_ADDR);
  assign unused_a = ^{a_q[1:0], a_q[DATA_W-1:ADDR_W+2]};

  // Present the incoming address while idle so the sync read is ready in BUSY.
  assign ram_addr = (state_q == DM_IDLE) ? bus.a[ADDR_W+1:2] : a_q[ADDR_W+1:2];

  dmem_resp_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (ram_addr),
    .wd_i   (wd_q),
    .rd_o   (ram_rd)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    rd_d        = rd_q;
    done_d      = done_q;
    done_data_d = done_data_q;
    latch       = 1'b0;
    mem_we      = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      DM_IDLE: if (bus.re || bus.we) begin
        latch   = 1'b1;
        we_d    = bus.we;
        cnt_d   = DM_CNT_W'(LATENCY - 1);
        state_d = DM_BUSY;
        stall   = 1'b1;
      end
      DM_BUSY: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DM_RESP;
          if (we_q) begin
            rd_d = '0;
            if (halt_hit) begin
              done_d      = 1'b1;
              done_data_d = wd_q;
            end else begin
              mem_we = 1'b1;
            end
          end else begin
            rd_d = halt_hit ? done_data_q : ram_rd;
          end
        end
      end
      DM_RESP: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
    acc_d = (state_q == DM_BUSY && cnt_q == '0) ? sat_inc(acc_q) : acc_q;
    stl_d = stall ? sat_inc(stl_q) : stl_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DM_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      rd_q        <= '0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      acc_q       <= '0;
      stl_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      acc_q       <= acc_d;
      stl_q       <= stl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      a_q  <= bus.a;
      wd_q <= bus.wd;
    end
  end

  assign bus.rd    = rd_q;
  assign bus.stall = stall;
  assign done      = done_q;
  assign done_data = done_data_q;
  assign acc_cnt   = acc_q;
  assign stall_cnt = stl_q;
endmodule
